fft4_stream: RTL and testbench

FFT4_STREAM -- requirements
Module: fft4_stream

---
 rtl/fft4_stream.sv | 171 +++++++++++++++++
 tb/tb_fft4_stream.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft4_stream.sv
// Streaming 4-point FFT/IFFT: collects 4 complex samples, transforms them in one
// combinational step into a 4-bin output buffer, then streams the bins out in order.
// Optional macro FFT4_STREAM_SAT_EN: saturate out-of-range results and raise the
// sticky o_overflow flag; when undefined, results wrap and o_overflow is tied 0.
module fft4_stream #(
  parameter int NB_INPUT   = 8,
  parameter int NBF_INPUT  = 7,
  parameter int NB_OUTPUT  = 10,
  parameter int NBF_OUTPUT = 7
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [2*NB_INPUT-1:0]  i_data,
  input  logic                   i_inverse,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [2*NB_OUTPUT-1:0] o_data,
  output logic [1:0]             o_index,
  output logic                   o_last,
  output logic                   o_overflow
);

  localparam int NS = NB_INPUT + 2;           // full-precision sum width
  localparam int SH = NBF_INPUT - NBF_OUTPUT; // fraction bits dropped (floor)

  typedef logic signed [NB_INPUT-1:0] comp_t;
  typedef logic signed [NS-1:0]       sum_t;
  typedef logic [2*NB_OUTPUT-1:0]     bin_t;

`ifdef FFT4_STREAM_SAT_EN
  localparam int signed OMAX = 2**(NB_OUTPUT-1) - 1;
  localparam int signed OMIN = -(2**(NB_OUTPUT-1));

  // Floor-truncate fraction, then clamp to the output integer range.
  function automatic logic [NB_OUTPUT-1:0] fit(input sum_t v);
    logic signed [31:0] w;
    w = 32'(v) >>> SH;
    if (w > OMAX)      return NB_OUTPUT'(OMAX);
    else if (w < OMIN) return NB_OUTPUT'(OMIN);
    else               return NB_OUTPUT'(w);
  endfunction

  function automatic logic oor(input sum_t v);
    logic signed [31:0] w;
    w = 32'(v) >>> SH;
    return (w > OMAX) || (w < OMIN);
  endfunction
`else
  // Floor-truncate fraction, then drop integer MSBs (wrap).
  function automatic logic [NB_OUTPUT-1:0] fit(input sum_t v);
    logic signed [31:0] w;
    w = 32'(v) >>> SH;
    return NB_OUTPUT'(w);
  endfunction
`endif

  logic [1:0] cnt;
  logic       frame_full;
  logic       inv_r;
  comp_t      xr [4];
  comp_t      xi [4];
  logic       ob_valid;
  logic [1:0] ob_idx;
  bin_t       ob_data [4];

  sum_t       vr [4], vi [4], xre [4], xim [4];
  sum_t       ar, ai, br, bi, pr, pi, qr, qi;
  bin_t       bin [4];
  logic       acc, last_in, xfer, buf_free, load;

  assign o_ready  = i_enable & ~frame_full;
  assign o_valid  = i_enable & ob_valid;
  assign o_data   = ob_data[ob_idx];
  assign o_index  = ob_idx;
  assign o_last   = o_valid & (ob_idx == 2'd3);

  assign acc      = i_valid & o_ready;
  assign last_in  = acc & (cnt == 2'd3);
  assign xfer     = o_valid & i_ready;
  // Buffer can take a frame when empty or when its last bin leaves this edge.
  assign buf_free = ~ob_valid | (xfer & (ob_idx == 2'd3));
  // A completing x3 goes straight into a free buffer, so throughput never drops.
  assign load     = i_enable & (frame_full | last_in) & buf_free;

  // Radix-4 butterfly on the collected frame; x3 bypasses from the input port
  // when the frame is completing this very cycle.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      vr[k] = sum_t'(xr[k]);
      vi[k] = sum_t'(xi[k]);
    end
    if (!frame_full) begin
      vr[3] = sum_t'($signed(i_data[2*NB_INPUT-1:NB_INPUT]));
      vi[3] = sum_t'($signed(i_data[NB_INPUT-1:0]));
    end
    pr = vr[0] + vr[2];  pi = vi[0] + vi[2];
    qr = vr[1] + vr[3];  qi = vi[1] + vi[3];
    ar = vr[0] - vr[2];  ai = vi[0] - vi[2];
    br = vr[1] - vr[3];  bi = vi[1] - vi[3];
    xre[0] = pr + qr;    xim[0] = pi + qi;
    xre[2] = pr - qr;    xim[2] = pi - qi;
    // forward: X1 = a - j*b, X3 = a + j*b; inverse swaps them
    xre[1] = ar + bi;    xim[1] = ai - br;
    xre[3] = ar - bi;    xim[3] = ai + br;
    if (inv_r) begin
      xre[1] = ar - bi;  xim[1] = ai + br;
      xre[3] = ar + bi;  xim[3] = ai - br;
    end
    for (int k = 0; k < 4; k++) bin[k] = {fit(xre[k]), fit(xim[k])};
  end

  // Input collection: sample counter, frame registers, frame_full handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt        <= '0;
      frame_full <= 1'b0;
      inv_r      <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        xr[k] <= '0;
        xi[k] <= '0;
      end
    end else begin
      if (acc) begin
        cnt     <= cnt + 2'd1;
        xr[cnt] <= $signed(i_data[2*NB_INPUT-1:NB_INPUT]);
        xi[cnt] <= $signed(i_data[NB_INPUT-1:0]);
        if (cnt == 2'd0) inv_r <= i_inverse;
      end
      if (load)         frame_full <= 1'b0;
      else if (last_in) frame_full <= 1'b1;
    end
  end

  // Output buffer: load a whole transformed frame, then step through bins 0..3.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ob_valid <= 1'b0;
      ob_idx   <= '0;
      for (int k = 0; k < 4; k++) ob_data[k] <= '0;
    end else if (load) begin
      ob_valid <= 1'b1;
      ob_idx   <= '0;
      for (int k = 0; k < 4; k++) ob_data[k] <= bin[k];
    end else if (xfer) begin
      ob_idx <= ob_idx + 2'd1;
      if (ob_idx == 2'd3) ob_valid <= 1'b0;
    end
  end

`ifdef FFT4_STREAM_SAT_EN
  logic ovf;

  // Any clamped component of the frame being loaded.
  always_comb begin
    ovf = 1'b0;
    for (int k = 0; k < 4; k++) ovf = ovf | oor(xre[k]) | oor(xim[k]);
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         o_overflow <= 1'b0;
    else if (load && ovf) o_overflow <= 1'b1;
  end
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fft4_stream.sv
// Bench for fft4_stream: a DFT-definition model fed from observed handshakes,
// one negedge compare process, and literal expectations for the key vectors.
module tb_fft4_stream;
  localparam int NBI = 8, NBFI = 7, NBO = 9, NBFO = 7;

  logic i_clk = 0, i_rst_n = 0, i_enable = 0, i_valid = 0, i_inverse = 0, i_ready = 1;
  logic [2*NBI-1:0] i_data = '0;
  logic o_ready, o_valid, o_last, o_overflow;
  logic [2*NBO-1:0] o_data;
  logic [1:0] o_index;

  int checks = 0, errors = 0;
  int rdy_low = 0, cyc = 0;

  typedef struct { logic [2*NBO-1:0] d; logic [1:0] i; } ebin_t;
  ebin_t expq[$];
  logic [2*NBO-1:0] got[$];
  int xcyc[$];
  int fre[4], fim[4], fcnt = 0;
  bit finv = 0;
  bit hold_v = 0;
  logic [2*NBO-1:0] hold_d;
  logic [1:0] hold_i;
  logic [2*NBO-1:0] lit_f[4], lit_i[4];

  always #5 i_clk = ~i_clk;

  fft4_stream #(.NB_INPUT(NBI), .NBF_INPUT(NBFI), .NB_OUTPUT(NBO), .NBF_OUTPUT(NBFO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_valid(i_valid),
    .o_ready(o_ready), .i_data(i_data), .i_inverse(i_inverse), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_index(o_index), .o_last(o_last),
    .o_overflow(o_overflow));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Output-range rule: floor the fraction, then clamp or wrap to NBO bits.
  function automatic logic [NBO-1:0] fitm(input int v);
    int w, mx, mn;
    w  = v >>> (NBFI - NBFO);
    mx = (1 << (NBO - 1)) - 1;
    mn = -(1 << (NBO - 1));
`ifdef FFT4_STREAM_SAT_EN
    if (w > mx) w = mx;
    if (w < mn) w = mn;
`endif
    return w[NBO-1:0];
  endfunction

  // X[k] = sum_n x[n] * W^(n*k), W = -j (forward) or +j (inverse).
  task automatic model_frame();
    ebin_t b;
    int sr, si, r, m, t;
    for (int k = 0; k < 4; k++) begin
      sr = 0; si = 0;
      for (int n = 0; n < 4; n++) begin
        r = fre[n]; m = fim[n];
        for (int q = 0; q < (n * k) % 4; q++) begin
          t = r;
          if (finv) begin r = -m; m = t; end
          else      begin r = m;  m = -t; end
        end
        sr += r; si += m;
      end
      b.d = {fitm(sr), fitm(si)};
      b.i = k[1:0];
      expq.push_back(b);
    end
  endtask

  // Single compare process: observes handshakes mid-cycle, feeds the model, checks bins.
  always @(negedge i_clk) begin
    ebin_t e;
    cyc++;
    if (!i_rst_n) begin
      fcnt = 0; expq.delete(); hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("hold_data", o_data, hold_d);
        chk("hold_index", o_index, hold_i);
      end
      hold_v = o_valid && !i_ready; hold_d = o_data; hold_i = o_index;
      if (!i_enable) chk("disabled_quiet", {o_ready, o_valid}, 0);
      if (i_enable && i_valid && !o_ready) rdy_low++;
      if (o_valid && i_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_bin: got %0h expected no bin pending", o_data);
        end else begin
          e = expq.pop_front();
          chk("bin_data", o_data, e.d);
          chk("bin_index", o_index, e.i);
          chk("bin_last", o_last, e.i == 2'd3);
        end
        got.push_back(o_data);
        xcyc.push_back(cyc);
      end
      if (i_enable && i_valid && o_ready) begin
        if (fcnt == 0) finv = i_inverse;
        fre[fcnt] = $signed(i_data[2*NBI-1:NBI]);
        fim[fcnt] = $signed(i_data[NBI-1:0]);
        fcnt++;
        if (fcnt == 4) begin model_frame(); fcnt = 0; end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic send(input int re, input int im, input bit inv);
    bit done;
    logic [NBI-1:0] r8, m8;
    r8 = re[NBI-1:0]; m8 = im[NBI-1:0];
    done = 0;
    i_valid = 1; i_data = {r8, m8}; i_inverse = inv;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge i_clk); done = o_ready;
      @(posedge i_clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no acceptance expected acceptance within 40 cycles");
    end
    i_valid = 0;
  endtask

  // Inverse flag is offered only with x0 to show it is latched there.
  task automatic send_frame(input int f[8], input bit inv);
    for (int n = 0; n < 4; n++) send(f[2*n], f[2*n+1], (n == 0) ? inv : !inv);
  endtask

  task automatic drain();
    for (int t = 0; t < 80 && expq.size() != 0; t++) tick();
    chk("drain_pending", expq.size(), 0);
  endtask

  task automatic do_reset();
    i_rst_n = 0; i_valid = 0;
    @(negedge i_clk);
    chk("reset_state", {o_valid, o_last, o_overflow, o_index, o_data}, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1;
  endtask

  task automatic clear_obs();
    got.delete(); xcyc.delete(); rdy_low = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int fa[8], fb[8], fc[8], fz[8], fimp[8], fsh[8];
    bit seen;
    fa   = '{10, 20, -30, 5, 127, -128, -1, -1};
    fb   = '{-128, 127, 100, -100, 3, -7, 55, 0};
    fc   = '{1, 2, 3, 4, 5, 6, 7, 8};
    fz   = '{-128, -128, -128, -128, -128, -128, -128, -128};
    fimp = '{64, 0, 0, 0, 0, 0, 0, 0};
    fsh  = '{0, 0, 64, 0, 0, 0, 0, 0};
    lit_f[0] = {9'd64, 9'd0};  lit_f[1] = {9'd0, 9'h1C0};
    lit_f[2] = {9'h1C0, 9'd0}; lit_f[3] = {9'd0, 9'd64};
    lit_i[0] = {9'd64, 9'd0};  lit_i[1] = {9'd0, 9'd64};
    lit_i[2] = {9'h1C0, 9'd0}; lit_i[3] = {9'd0, 9'h1C0};

    do_reset();
    i_enable = 1;
    tick();
    chk("idle_after_reset", {o_valid, o_ready}, 2'b01);

    // impulse, plus bin-0 latency right after the x3 edge
    clear_obs();
    send_frame(fimp, 0);
    chk("latency_bin0", {o_valid, o_index}, 3'b100);
    drain();
    for (int k = 0; k < 4; k++) chk($sformatf("impulse_bin%0d", k), got[k], {9'd64, 9'd0});
    chk("impulse_no_ovf", o_overflow, 0);

    // shifted impulse forward and inverse
    clear_obs();
    send_frame(fsh, 0);
    drain();
    for (int k = 0; k < 4; k++) chk($sformatf("shift_fwd_bin%0d", k), got[k], lit_f[k]);
    clear_obs();
    send_frame(fsh, 1);
    drain();
    for (int k = 0; k < 4; k++) chk($sformatf("shift_inv_bin%0d", k), got[k], lit_i[k]);

    // back-to-back frames at full rate
    clear_obs();
    send_frame(fa, 0);
    send_frame(fb, 1);
    drain();
    chk("b2b_bins", got.size(), 8);
    chk("b2b_ready_low", rdy_low, 0);
    chk("b2b_consecutive", xcyc[7] - xcyc[0], 7);

    // backpressure during bin 1 while frames keep arriving
    clear_obs();
    send_frame(fa, 0);
    fork
      begin
        send_frame(fb, 1);
        send_frame(fc, 0);
      end
      begin : stall
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
          tick();
          seen = o_valid && (o_index == 2'd1);
        end
        chk("bp_reached_bin1", seen, 1);
        i_ready = 0;
        repeat (3) @(posedge i_clk);
        #1 i_ready = 1;
      end
    join
    drain();
    chk("bp_bins", got.size(), 12);
    chk("bp_ready_low_cycles", rdy_low, 3);

    // enable low mid-frame and mid-output
    clear_obs();
    send(10, -10, 1);
    send(20, 0, 0);
    i_enable = 0; i_valid = 1; i_data = 16'h7F7F;
    repeat (3) tick();
    i_enable = 1; i_valid = 0;
    send(-5, 33, 0);
    send(0, 64, 0);
    i_enable = 0;
    repeat (2) tick();
    i_enable = 1;
    drain();
    chk("enable_bins", got.size(), 4);

    // reset after x1, then a fresh frame
    clear_obs();
    send(1, 1, 0);
    send(2, 2, 0);
    do_reset();
    repeat (2) tick();
    chk("reset_midframe_idle", o_valid, 0);
    send_frame(fsh, 0);
    drain();
    for (int k = 0; k < 4; k++) chk($sformatf("fresh_bin%0d", k), got[k], lit_f[k]);

    // reset while bins are pending
    clear_obs();
    send_frame(fb, 0);
    tick();
    do_reset();
    repeat (3) tick();
    chk("reset_midoutput_idle", o_valid, 0);

    // overflow: all -128 makes X0 = -512-512j
    clear_obs();
    send_frame(fz, 0);
    drain();
`ifdef FFT4_STREAM_SAT_EN
    chk("ovf_x0", got[0], {9'h100, 9'h100});
    chk("ovf_flag", o_overflow, 1);
`else
    chk("ovf_x0", got[0], 0);
    chk("ovf_flag", o_overflow, 0);
`endif
    chk("ovf_x1", got[1], 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
